dom_vk_call_sequencer: RTL and testbench

Upstream feeder for `emscripten_dom_vk_to_string`. It buffers incoming DOM keyboard virtual-key codes and issues them one at a time over the converter's call interface (`start`/`busy`, `done`/`stall`). It pairs each returned 64-bit string pointer with its originating code on a ready/valid result stream. It also counts calls that return a null pointer (unmapped key codes).

---
 rtl/dom_vk_pkg.sv | 26 ++
 rtl/dom_vk_call_sequencer_if.sv | 51 +++++
 rtl/dom_vk_fifo.sv | 75 +++++++
 rtl/dom_vk_call_sequencer.sv | 132 +++++++++++++
 tb/tb_dom_vk_call_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dom_vk_pkg.sv
// -----------------------------------------------------------------------------
// dom_vk_pkg
// Shared types and constants for the DOM virtual-key call sequencer.
//   vk_seq_state_t : sequencer FSM state encoding
//   VK_CODE_W      : width of a DOM VK code
//   VK_PTR_W       : width of the string pointer returned by the converter
//   VK_NULL_PTR    : pointer value meaning "no string for this code"
// -----------------------------------------------------------------------------
package dom_vk_pkg;

    localparam int VK_CODE_W = 32;
    localparam int VK_PTR_W  = 64;

    localparam logic [VK_PTR_W-1:0] VK_NULL_PTR = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } vk_seq_state_t;

    function automatic logic vk_is_null(input logic [VK_PTR_W-1:0] ptr);
        return (ptr == VK_NULL_PTR);
    endfunction

endpackage

// File: rtl/dom_vk_call_sequencer_if.sv
// -----------------------------------------------------------------------------
// dom_vk_call_sequencer_if
// Bundles the three streams around the sequencer:
//   evt_*  : key events in (valid/ready)
//   vk_*   : call/return channel to the converter (start/busy, done/stall)
//   res_*  : paired code/pointer results out (valid/ready), plus null_count
// Modports:
//   slave  : the sequencer side
//   master : the environment side (event source, converter, result sink)
// -----------------------------------------------------------------------------
interface dom_vk_call_sequencer_if #(
    parameter int CNT_W = 16
);
    import dom_vk_pkg::*;

    logic                 evt_valid;
    logic                 evt_ready;
    logic [VK_CODE_W-1:0] evt_code;

    logic                 vk_start;
    logic                 vk_busy;
    logic [VK_CODE_W-1:0] vk_code;
    logic                 vk_done;
    logic                 vk_stall;
    logic [VK_PTR_W-1:0]  vk_returndata;

    logic                 res_valid;
    logic                 res_ready;
    logic [VK_CODE_W-1:0] res_code;
    logic [VK_PTR_W-1:0]  res_ptr;
    logic [CNT_W-1:0]     null_count;

    modport slave (
        input  evt_valid, evt_code,
        output evt_ready,
        output vk_start, vk_code, vk_stall,
        input  vk_busy, vk_done, vk_returndata,
        output res_valid, res_code, res_ptr, null_count,
        input  res_ready
    );

    modport master (
        output evt_valid, evt_code,
        input  evt_ready,
        input  vk_start, vk_code, vk_stall,
        output vk_busy, vk_done, vk_returndata,
        input  res_valid, res_code, res_ptr, null_count,
        output res_ready
    );

endinterface

// File: rtl/dom_vk_fifo.sv
// -----------------------------------------------------------------------------
// dom_vk_fifo
// Generic synchronous FIFO, registered pointers, combinational head read.
// Ports:
//   clock, resetn : clock (rising edge), async active-low reset
//   i_push/i_data : write strobe and data (ignored while full)
//   i_pop         : read strobe (ignored while empty)
//   o_data        : current head entry
//   o_full/o_empty/o_count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module dom_vk_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    // Storage is not reset; only the pointers/count define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dom_vk_call_sequencer.sv
// -----------------------------------------------------------------------------
// dom_vk_call_sequencer
// Buffers DOM VK codes, issues them one at a time to the VK-to-string
// converter, and pairs each returned pointer with its code on a result stream.
// Results carrying a null pointer are counted (saturating).
// Ports:
//   clock, resetn : clock (rising edge), async active-low reset
//   bus (slave)   : evt_* input stream, vk_* converter channel,
//                   res_* result stream, null_count
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no call in flight; pops the FIFO head into cur_code if present
// ISSUE | vk_start high with vk_code=cur_code until converter not busy
// WAIT  | call accepted; waiting for an unstalled vk_done to capture result
// -----------------------------------------------------------------------------
module dom_vk_call_sequencer
    import dom_vk_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic                    clock,
    input logic                    resetn,
    dom_vk_call_sequencer_if.slave bus
);

    localparam int                AW      = $clog2(DEPTH);
    localparam logic [AW:0]       CNT_DEP = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  NC_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  NC_MAX  = '1;

    vk_seq_state_t        r_state;
    logic                 r_vk_start;
    logic [VK_CODE_W-1:0] r_cur_code;
    logic                 r_res_valid;
    logic [VK_CODE_W-1:0] r_res_code;
    logic [VK_PTR_W-1:0]  r_res_ptr;
    logic [CNT_W-1:0]     r_null_count;

    logic                 w_fifo_push;
    logic                 w_fifo_pop;
    logic [VK_CODE_W-1:0] w_fifo_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [AW:0]          w_fifo_count;
    logic                 w_vk_stall;
    logic                 w_done_acc;

    assign w_fifo_push = bus.evt_valid & ~w_fifo_full;
    assign w_fifo_pop  = (r_state == IDLE) & ~w_fifo_empty;

    dom_vk_fifo #(
        .WIDTH (VK_CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (w_fifo_push),
        .i_data  (bus.evt_code),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // The result slot is free either when empty or when it drains this cycle,
    // so a new result can be captured in the same cycle the old one leaves.
    assign w_vk_stall = r_res_valid & ~bus.res_ready;
    assign w_done_acc = (r_state == WAIT) & bus.vk_done & ~w_vk_stall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_vk_start   <= 1'b0;
            r_cur_code   <= '0;
            r_res_valid  <= 1'b0;
            r_res_code   <= '0;
            r_res_ptr    <= '0;
            r_null_count <= '0;
        end else begin
            if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_cur_code <= w_fifo_data;
                        r_vk_start <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!bus.vk_busy) begin
                        r_vk_start <= 1'b0;
                        r_state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (w_done_acc) begin
                        r_res_valid <= 1'b1;
                        r_res_code  <= r_cur_code;
                        r_res_ptr   <= bus.vk_returndata;
                        if (vk_is_null(bus.vk_returndata) && (r_null_count != NC_MAX)) begin
                            r_null_count <= r_null_count + NC_ONE;
                        end
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_vk_start <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.evt_ready  = (w_fifo_count < CNT_DEP);
    assign bus.vk_start   = r_vk_start;
    assign bus.vk_code    = r_cur_code;
    assign bus.vk_stall   = w_vk_stall;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_code   = r_res_code;
    assign bus.res_ptr    = r_res_ptr;
    assign bus.null_count = r_null_count;

endmodule

// File: tb/tb_dom_vk_call_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dom_vk_call_sequencer
// Drives key events, models the converter and the result consumer, and
// scoreboards every result against the code pushed and the pointer the
// converter model returns for it.
// -----------------------------------------------------------------------------
module tb_dom_vk_call_sequencer;
    import dom_vk_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [VK_CODE_W-1:0] code;
        logic [VK_PTR_W-1:0]  ptr;
    } exp_t;

    logic clock;
    logic resetn;

    dom_vk_call_sequencer_if #(.CNT_W(CNT_W)) vif ();

    dom_vk_call_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (vif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] evt_q [$];
    exp_t        exp_q [$];

    bit          busy_on    = 1'b0;
    bit          rdy_en     = 1'b1;
    bit          conv_hold  = 1'b0;
    bit          spur       = 1'b0;
    bit          conv_pending = 1'b0;
    logic [31:0] conv_code  = '0;
    int          conv_cnt   = 0;
    int          conv_lat   = 2;
    int          call_cnt   = 0;
    int          start_cycles = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ptr_of(input logic [31:0] code);
        case (code)
            32'd65:                        return 64'h1000;
            32'd100, 32'd102, 32'd103,
            32'd104:                       return 64'h0;
            32'd101:                       return 64'h20;
            default:                       return {32'hBEEF_0000, code};
        endcase
    endfunction

    // Event source, converter model and result sink; drives on the falling
    // edge, then evaluates the handshakes the next rising edge will see.
    initial begin : driver
        exp_t e;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                vif.evt_valid = 1'b0;
                vif.vk_done   = 1'b0;
                vif.vk_busy   = 1'b0;
                continue;
            end
            vif.evt_valid = (evt_q.size() > 0);
            vif.evt_code  = (evt_q.size() > 0) ? evt_q[0] : 32'h0;
            vif.vk_busy   = busy_on;
            vif.res_ready = rdy_en;
            if (spur) begin
                vif.vk_done       = 1'b1;
                vif.vk_returndata = 64'h0;
            end else if (conv_pending && conv_cnt == 0 && !conv_hold) begin
                vif.vk_done       = 1'b1;
                vif.vk_returndata = ptr_of(conv_code);
            end else begin
                vif.vk_done       = 1'b0;
            end
            #1;
            if (vif.vk_start) start_cycles++;
            if (vif.res_valid && vif.res_ready) begin
                chk("res_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("res_code", 64'(vif.res_code), 64'(e.code));
                    chk("res_ptr", vif.res_ptr, e.ptr);
                end
            end
            if (conv_pending && !spur && vif.vk_done && !vif.vk_stall) begin
                conv_pending = 1'b0;
            end else if (conv_pending && conv_cnt > 0) begin
                conv_cnt--;
            end
            if (vif.vk_start && !vif.vk_busy) begin
                chk("one_outstanding", 64'(conv_pending), 64'd0);
                conv_pending = 1'b1;
                conv_code    = vif.vk_code;
                conv_cnt     = conv_lat;
                call_cnt++;
            end
            if (vif.evt_valid && vif.evt_ready) begin
                exp_q.push_back('{code: evt_q[0], ptr: ptr_of(evt_q[0])});
                void'(evt_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((evt_q.size() > 0 || exp_q.size() > 0 || conv_pending) && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_drained"},
            64'(evt_q.size() == 0 && exp_q.size() == 0 && !conv_pending), 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0;
        int n;
        vif.evt_valid     = 1'b0;
        vif.evt_code      = '0;
        vif.vk_busy       = 1'b0;
        vif.vk_done       = 1'b0;
        vif.vk_returndata = '0;
        vif.res_ready     = 1'b1;
        resetn            = 1'b0;
        #3;
        chk("rst_evt_ready", 64'(vif.evt_ready), 64'd1);
        chk("rst_vk_start", 64'(vif.vk_start), 64'd0);
        chk("rst_vk_code", 64'(vif.vk_code), 64'd0);
        chk("rst_vk_stall", 64'(vif.vk_stall), 64'd0);
        chk("rst_res_valid", 64'(vif.res_valid), 64'd0);
        chk("rst_res_code", 64'(vif.res_code), 64'd0);
        chk("rst_res_ptr", vif.res_ptr, 64'd0);
        chk("rst_null_count", 64'(vif.null_count), 64'd0);
        step(3);
        resetn = 1'b1;

        // Single event
        start_cycles = 0;
        evt_q.push_back(32'd65);
        wait_idle("single", 60);
        chk("single_start_cycles", 64'(start_cycles), 64'd1);

        // Busy hold
        busy_on = 1'b1;
        evt_q.push_back(32'd66);
        n = 0;
        while (!vif.vk_start && n < 20) begin step(1); n++; end
        chk("busy_start_seen", 64'(vif.vk_start), 64'd1);
        c0 = call_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("busy_start_hold", 64'(vif.vk_start), 64'd1);
            chk("busy_code_hold", 64'(vif.vk_code), 64'd66);
            step(1);
        end
        chk("busy_no_call", 64'(call_cnt), 64'(c0));
        busy_on = 1'b0;
        wait_idle("busy", 60);
        chk("busy_one_call", 64'(call_cnt), 64'(c0 + 1));

        // FIFO full: code 1 sits in ISSUE, 2..9 fill the FIFO, 10 is held
        busy_on = 1'b1;
        for (int i = 1; i <= 10; i++) evt_q.push_back(32'(i));
        step(16);
        chk("full_evt_ready", 64'(vif.evt_ready), 64'd0);
        chk("full_held_events", 64'(evt_q.size()), 64'd1);
        chk("full_issue_code", 64'(vif.vk_code), 64'd1);
        busy_on = 1'b0;
        wait_idle("full", 300);

        // Result backpressure
        rdy_en = 1'b0;
        evt_q.push_back(32'd20);
        evt_q.push_back(32'd21);
        n = 0;
        while (!(conv_pending && conv_code == 32'd21 && vif.vk_done) && n < 100) begin
            step(1); n++;
        end
        step(3);
        chk("bp_stall", 64'(vif.vk_stall), 64'd1);
        chk("bp_res_valid", 64'(vif.res_valid), 64'd1);
        chk("bp_res_code", 64'(vif.res_code), 64'd20);
        chk("bp_res_ptr", vif.res_ptr, ptr_of(32'd20));
        chk("bp_conv_held", 64'(conv_pending), 64'd1);
        rdy_en = 1'b1;
        wait_idle("bp", 60);

        // Spurious done outside WAIT
        spur = 1'b1;
        step(3);
        spur = 1'b0;
        step(2);
        chk("spur_res_valid", 64'(vif.res_valid), 64'd0);
        chk("spur_null_count", 64'(vif.null_count), 64'd0);

        // Null count and saturation (2-bit counter)
        evt_q.push_back(32'd100);
        evt_q.push_back(32'd101);
        evt_q.push_back(32'd102);
        wait_idle("null", 100);
        chk("null_count_2", 64'(vif.null_count), 64'd2);
        evt_q.push_back(32'd103);
        wait_idle("null3", 60);
        chk("null_count_max", 64'(vif.null_count), 64'd3);
        evt_q.push_back(32'd104);
        wait_idle("null_sat", 60);
        chk("null_count_sat", 64'(vif.null_count), 64'd3);

        // Async reset mid-call with 3 codes queued
        conv_hold = 1'b1;
        c0 = call_cnt;
        for (int i = 30; i <= 33; i++) evt_q.push_back(32'(i));
        n = 0;
        while (!(call_cnt == c0 + 1 && evt_q.size() == 0) && n < 40) begin step(1); n++; end
        step(3);
        chk("rmc_in_call", 64'(conv_pending), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rmc_evt_ready", 64'(vif.evt_ready), 64'd1);
        chk("rmc_vk_start", 64'(vif.vk_start), 64'd0);
        chk("rmc_vk_code", 64'(vif.vk_code), 64'd0);
        chk("rmc_vk_stall", 64'(vif.vk_stall), 64'd0);
        chk("rmc_res_valid", 64'(vif.res_valid), 64'd0);
        chk("rmc_res_code", 64'(vif.res_code), 64'd0);
        chk("rmc_res_ptr", vif.res_ptr, 64'd0);
        chk("rmc_null_count", 64'(vif.null_count), 64'd0);
        evt_q.delete();
        exp_q.delete();
        conv_pending = 1'b0;
        conv_hold    = 1'b0;
        step(2);
        start_cycles = 0;
        resetn = 1'b1;
        step(6);
        chk("post_rst_no_start", 64'(start_cycles), 64'd0);
        chk("post_rst_evt_ready", 64'(vif.evt_ready), 64'd1);
        evt_q.push_back(32'd40);
        wait_idle("post_rst", 60);
        chk("post_rst_null", 64'(vif.null_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
